// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a level irq.
// Define TIMER_PRESCALE_EN to add an 8-bit prescaler controlled by CTRL.PS (bits 15:8).
module timer_dev (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state, state_nxt;
    logic        en, en_nxt;
    logic [1:0]  mode, mode_nxt;
    logic        im, im_nxt;
    logic [7:0]  ps;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        ctrl_wr;
    logic        tick;
    logic        auto_rld;

    assign ctrl_wr  = we && (addr == A_CTRL);
    assign auto_rld = (mode == 2'b01);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] pscnt;
    logic       unused_din;

    assign unused_din = ^{din[31:16], din[7:4]};
    assign tick       = (pscnt == ps);

    // Prescaler restarts on every reload and on any CTRL write so the first tick is a full PS+1 away.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps    <= 8'd0;
            pscnt <= 8'd0;
        end else begin
            if (ctrl_wr)
                ps <= din[15:8];
            if (ctrl_wr || state == LOAD || (state == CNT && tick))
                pscnt <= 8'd0;
            else if (state == CNT)
                pscnt <= pscnt + 8'd1;
        end
    end
`else
    logic unused_din;

    assign unused_din = ^{din[31:8], din[7:4]};
    assign ps         = 8'd0;
    assign tick       = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        en_nxt    = en;
        mode_nxt  = mode;
        im_nxt    = im;
        if (ctrl_wr) begin
            en_nxt   = din[0];
            mode_nxt = din[2:1];
            im_nxt   = din[3];
            if (!din[0])
                state_nxt = IDLE;
            else if (state == IDLE || state == INT)
                state_nxt = LOAD;
        end else begin
            unique case (state)
                IDLE: begin
                end
                LOAD: begin
                    count_nxt = preset;
                    if (preset == 32'd0) begin
                        state_nxt = INT;
                        if (!auto_rld)
                            en_nxt = 1'b0;
                    end else begin
                        state_nxt = CNT;
                    end
                end
                CNT: begin
                    if (tick) begin
                        // Saturate at zero: reaching 1 (or an unexpected 0) ends the period.
                        if (count <= 32'd1) begin
                            count_nxt = 32'd0;
                            state_nxt = INT;
                            if (!auto_rld)
                                en_nxt = 1'b0;
                        end else begin
                            count_nxt = count - 32'd1;
                        end
                    end
                end
                INT: begin
                    if (auto_rld)
                        state_nxt = LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= 32'd0;
            preset <= 32'd0;
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            en    <= en_nxt;
            mode  <= mode_nxt;
            im    <= im_nxt;
            if (we && addr == A_PRESET)
                preset <= din;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            A_CTRL:   dout = {16'd0, ps, 4'd0, im, mode, en};
            A_PRESET: dout = preset;
            A_COUNT:  dout = count;
            default:  dout = 32'd0;
        endcase
    end

    // Driven purely from registers, so din cannot reach irq combinationally.
    assign irq = im && (state == INT);

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: vector table, directed corner sequences, and
// randomized runs checked against a closed-form timing model.
module tb_timer_dev;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    timer_dev dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic        w;
        logic [31:0] d;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        we   = 1'b1;
        din  = d;
        cyc();
        we   = 1'b0;
    endtask

    task automatic rchk(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, dout, exp);
    endtask

    // Timing model, k = edges since the edge that sampled the enabling CTRL write.
    // COUNT shows PRESET at k=1 and falls by one per edge; INT is reached at k=PRESET+1.
    // Auto-reload repeats with period PRESET+2 (INT then LOAD, both with COUNT=0).
    function automatic void model(input int p, input logic [1:0] m, input int k,
                                  output int cnt, output bit intst);
        int ph;
        if (m == 2'b01) begin
            ph    = (k - 1) % (p + 2);
            cnt   = (ph <= p) ? (p - ph) : 0;
            intst = (ph == p);
        end else begin
            cnt   = (k - 1 <= p) ? (p - (k - 1)) : 0;
            intst = (k >= p + 1);
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int          n_hi;
        int          p, kmax, cnt;
        bit          intst;
        logic [31:0] ctl, exp_ctrl, exp_d;
        logic [1:0]  ra;

        vt[0] = '{2'd1, 1'b1, 32'd3,    32'd3, 1'b0};
        vt[1] = '{2'd0, 1'b1, 32'h9,    32'h9, 1'b0};
        vt[2] = '{2'd2, 1'b0, 32'd0,    32'd3, 1'b0};
        vt[3] = '{2'd2, 1'b0, 32'd0,    32'd2, 1'b0};
        vt[4] = '{2'd2, 1'b0, 32'd0,    32'd1, 1'b0};
        vt[5] = '{2'd2, 1'b0, 32'd0,    32'd0, 1'b1};
        vt[6] = '{2'd0, 1'b0, 32'd0,    32'h8, 1'b1};
        vt[7] = '{2'd0, 1'b1, 32'd0,    32'h0, 1'b0};
        vt[8] = '{2'd3, 1'b1, 32'h55,   32'h0, 1'b0};
        vt[9] = '{2'd2, 1'b0, 32'd0,    32'd0, 1'b0};

        rst = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;
        repeat (2) cyc();
        rst = 1'b0;
        chk("reset_irq", irq, 1'b0);
        rchk("reset_ctrl", 2'd0, 32'd0);
        rchk("reset_preset", 2'd1, 32'd0);
        rchk("reset_count", 2'd2, 32'd0);

        // one-shot walk-through as a vector table
        for (int i = 0; i < 10; i++) begin
            addr = vt[i].a; we = vt[i].w; din = vt[i].d;
            cyc();
            we = 1'b0;
            chk($sformatf("vec%0d_dout", i), dout, vt[i].exp_dout);
            chk($sformatf("vec%0d_irq", i), irq, vt[i].exp_irq);
        end

        // auto-reload, PRESET changed mid-count takes effect after the next LOAD
        wr(2'd0, 32'd0); wr(2'd1, 32'd2); wr(2'd0, 32'hB);
        for (int k = 1; k <= 30; k++) begin
            if (k == 6) begin
                addr = 2'd1; we = 1'b1; din = 32'd5;
            end else begin
                addr = 2'd2; we = 1'b0;
            end
            cyc();
            we = 1'b0;
            chk($sformatf("auto_irq_k%0d", k), irq,
                (k == 3 || k == 7 || k == 14 || k == 21 || k == 28) ? 1'b1 : 1'b0);
        end
        rchk("auto_en_kept", 2'd0, 32'hB);

        // PRESET=0: irq one edge after enable; IM=0 hides irq while EN still clears
        wr(2'd0, 32'd0); wr(2'd1, 32'd0); wr(2'd0, 32'h9);
        chk("p0_irq_k0", irq, 1'b0);
        cyc();
        chk("p0_irq_k1", irq, 1'b1);
        rchk("p0_ctrl", 2'd0, 32'h8);
        wr(2'd0, 32'h1);
        chk("p0_im0_irq_load", irq, 1'b0);
        cyc();
        chk("p0_im0_irq_int", irq, 1'b0);
        rchk("p0_im0_en_clr", 2'd0, 32'h0);

        // CTRL write with EN=1 during CNT: no tick that cycle, IM takes effect
        wr(2'd0, 32'd0); wr(2'd1, 32'd5); wr(2'd0, 32'h1);
        repeat (2) cyc();
        wr(2'd0, 32'h9);
        rchk("cnt_wr_hold", 2'd2, 32'd4);
        rchk("cnt_wr_ctrl", 2'd0, 32'h9);
        repeat (3) cyc();
        chk("cnt_wr_irq_early", irq, 1'b0);
        cyc();
        chk("cnt_wr_irq", irq, 1'b1);

        // reset mid-count overrides a simultaneous CTRL write
        wr(2'd0, 32'd0); wr(2'd1, 32'd100); wr(2'd0, 32'h9);
        repeat (51) cyc();
        rchk("rst_pre_count", 2'd2, 32'd50);
        rst = 1'b1; addr = 2'd0; we = 1'b1; din = 32'h9;
        cyc();
        rst = 1'b0; we = 1'b0;
        chk("rst_irq", irq, 1'b0);
        rchk("rst_ctrl", 2'd0, 32'd0);
        rchk("rst_preset", 2'd1, 32'd0);
        rchk("rst_count", 2'd2, 32'd0);
        n_hi = 0;
        repeat (110) begin
            cyc();
            if (irq) n_hi++;
        end
        chk("rst_no_irq_after", n_hi, 32'd0);

        // disable mid-count holds COUNT; COUNT is read-only
        wr(2'd1, 32'd10); wr(2'd0, 32'h1);
        repeat (4) cyc();
        rchk("dis_count_pre", 2'd2, 32'd7);
        wr(2'd0, 32'h0);
        rchk("dis_count_hold", 2'd2, 32'd7);
        chk("dis_irq", irq, 1'b0);
        wr(2'd2, 32'h55);
        rchk("dis_count_ro", 2'd2, 32'd7);
        wr(2'd3, 32'h77);
        repeat (3) cyc();
        rchk("dis_count_idle", 2'd2, 32'd7);

        // maximal PRESET counts down without wrapping
        wr(2'd0, 32'd0); wr(2'd1, 32'hFFFF_FFFF); wr(2'd0, 32'h9);
        cyc();
        rchk("max_k1", 2'd2, 32'hFFFF_FFFF);
        repeat (2) cyc();
        rchk("max_k3", 2'd2, 32'hFFFF_FFFD);
        chk("max_irq", irq, 1'b0);

`ifdef TIMER_PRESCALE_EN
        wr(2'd0, 32'd0); wr(2'd1, 32'd2); wr(2'd0, 32'h0309);
        rchk("ps_ctrl", 2'd0, 32'h0309);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk($sformatf("ps_irq_k%0d", k), irq, (k == 9) ? 1'b1 : 1'b0);
        end
        rchk("ps_ctrl_done", 2'd0, 32'h0308);
`else
        wr(2'd0, 32'h0000_FF09);
        rchk("nops_ctrl_hi", 2'd0, 32'h9);
`endif

        // randomized runs against the timing model
        for (int it = 0; it < 40; it++) begin
            p   = $urandom_range(0, 12);
            ctl = $urandom;
            ctl[15:8] = 8'd0;
            ctl[0]    = 1'b1;
            wr(2'd0, 32'd0);
            wr(2'd1, p);
            wr(2'd0, ctl);
            kmax = $urandom_range(1, 3 * p + 8);
            for (int k = 1; k <= kmax; k++) begin
                ra   = 2'($urandom_range(0, 3));
                addr = ra;
                we   = (ra >= 2'd2) && ($urandom_range(0, 1) == 1);
                din  = $urandom;
                cyc();
                we = 1'b0;
                model(p, ctl[2:1], k, cnt, intst);
                exp_ctrl = ctl & 32'hF;
                if (intst && ctl[2:1] != 2'b01) exp_ctrl[0] = 1'b0;
                case (ra)
                    2'd0:    exp_d = exp_ctrl;
                    2'd1:    exp_d = p;
                    2'd2:    exp_d = cnt;
                    default: exp_d = 32'd0;
                endcase
                chk($sformatf("rand%0d_k%0d_dout_a%0d", it, k, ra), dout, exp_d);
                chk($sformatf("rand%0d_k%0d_irq", it, k), irq, ctl[3] & intst);
            end
        end
        wr(2'd0, 32'd0);
        chk("final_irq", irq, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
